// File: rtl/ssd_scan_capture_if.sv
// Display-scan observation bundle: the anode/segment stream plus the decoded word and status pulses.
interface ssd_scan_capture_if;
  logic        capture_en;
  logic [3:0]  ANODES;
  logic [6:0]  LED_OUT;
  logic [15:0] value;
  logic        frame_valid;
  logic        seg_err;
  logic        anode_err;

  modport master (
    output capture_en, ANODES, LED_OUT,
    input  value, frame_valid, seg_err, anode_err
  );

  modport slave (
    input  capture_en, ANODES, LED_OUT,
    output value, frame_valid, seg_err, anode_err
  );
endinterface

// File: rtl/ssd_scan_capture.sv
// Observes a multiplexed seven-segment scan, decodes each settled digit to hex and
// publishes complete four-digit frames as a 16-bit word with single-cycle status pulses.
module ssd_scan_capture #(
  parameter int SETTLE_CYCLES  = 4,
  parameter bit SEG_ACTIVE_LOW = 1'b1
) (
  input logic           clk,
  input logic           rst,
  ssd_scan_capture_if.slave bus
);

  localparam int CW = $clog2(SETTLE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_MAX  = CW'(SETTLE_CYCLES);
  localparam logic [CW-1:0] CNT_EVAL = CW'(SETTLE_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    HOLD   = 2'd2
  } state_t;

  // Returns {valid, nibble} for an active-low {a..g} pattern.
  function automatic logic [4:0] font_decode(input logic [6:0] seg);
    logic [4:0] r;
    case (seg)
      7'h01:   r = 5'h10;
      7'h4F:   r = 5'h11;
      7'h12:   r = 5'h12;
      7'h06:   r = 5'h13;
      7'h4C:   r = 5'h14;
      7'h24:   r = 5'h15;
      7'h20:   r = 5'h16;
      7'h0F:   r = 5'h17;
      7'h00:   r = 5'h18;
      7'h04:   r = 5'h19;
      7'h08:   r = 5'h1A;
      7'h60:   r = 5'h1B;
      7'h31:   r = 5'h1C;
      7'h42:   r = 5'h1D;
      7'h30:   r = 5'h1E;
      7'h38:   r = 5'h1F;
      default: r = 5'h00;
    endcase
    return r;
  endfunction

  function automatic logic [2:0] anode_decode(input logic [3:0] a);
    logic [2:0] r;
    case (a)
      4'b1110: r = 3'b100;
      4'b1101: r = 3'b101;
      4'b1011: r = 3'b110;
      4'b0111: r = 3'b111;
      default: r = 3'b000;
    endcase
    return r;
  endfunction

  state_t          state_q;
  logic [3:0]      a_meta_q, sa_q, sa_prev_q;
  logic [6:0]      s_meta_q, ss_q;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [3:0]      seen_q;
  logic [15:0]     staging_q, value_q;
  logic            frame_valid_q, seg_err_q, anode_err_q;

  logic            sa_changed_s;
  logic            eval_s;
  logic [6:0]      seg_norm_s;
  logic [4:0]      font_s;
  logic [2:0]      anode_s;

  // Dwell counter next state and evaluate-step decode.
  always_comb begin
    sa_changed_s = (sa_q != sa_prev_q);
    if (sa_changed_s) begin
      cnt_d = '0;
    end else if (cnt_q != CNT_MAX) begin
      cnt_d = cnt_q + {{(CW-1){1'b0}}, 1'b1};
    end else begin
      cnt_d = cnt_q;
    end
    if (SEG_ACTIVE_LOW) begin
      seg_norm_s = ss_q;
    end else begin
      seg_norm_s = ~ss_q;
    end
    font_s  = font_decode(seg_norm_s);
    anode_s = anode_decode(sa_q);
    eval_s  = (state_q == SETTLE) && bus.capture_en && !sa_changed_s && (cnt_q == CNT_EVAL);
  end

  // Input synchronizers and dwell tracking.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      a_meta_q  <= 4'b0000;
      sa_q      <= 4'b0000;
      sa_prev_q <= 4'b0000;
      s_meta_q  <= 7'b0000000;
      ss_q      <= 7'b0000000;
      cnt_q     <= '0;
    end else begin
      a_meta_q  <= bus.ANODES;
      sa_q      <= a_meta_q;
      sa_prev_q <= sa_q;
      s_meta_q  <= bus.LED_OUT;
      ss_q      <= s_meta_q;
      cnt_q     <= cnt_d;
    end
  end

  // Scan FSM, frame assembly and registered status pulses.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= IDLE;
      seen_q        <= 4'b0000;
      staging_q     <= 16'h0000;
      value_q       <= 16'h0000;
      frame_valid_q <= 1'b0;
      seg_err_q     <= 1'b0;
      anode_err_q   <= 1'b0;
    end else begin
      frame_valid_q <= 1'b0;
      seg_err_q     <= 1'b0;
      anode_err_q   <= 1'b0;
      if (!bus.capture_en) begin
        state_q   <= IDLE;
        seen_q    <= 4'b0000;
        staging_q <= 16'h0000;
      end else begin
        // The cycle after the last digit lands is never an evaluate cycle, so no overlap here.
        if (seen_q == 4'b1111) begin
          value_q       <= staging_q;
          frame_valid_q <= 1'b1;
          seen_q        <= 4'b0000;
        end
        case (state_q)
          IDLE: begin
            if (sa_q != 4'b1111) begin
              state_q <= SETTLE;
            end else begin
              state_q <= IDLE;
            end
          end
          SETTLE: begin
            if (sa_q == 4'b1111) begin
              state_q <= IDLE;
            end else if (eval_s) begin
              state_q <= HOLD;
              if (!anode_s[2]) begin
                anode_err_q <= 1'b1;
                seen_q      <= 4'b0000;
              end else if (!font_s[4]) begin
                seg_err_q <= 1'b1;
                seen_q    <= 4'b0000;
              end else begin
                staging_q[{anode_s[1:0], 2'b00} +: 4] <= font_s[3:0];
                seen_q[anode_s[1:0]]                  <= 1'b1;
              end
            end else begin
              state_q <= SETTLE;
            end
          end
          HOLD: begin
            if (!sa_changed_s) begin
              state_q <= HOLD;
            end else if (sa_q == 4'b1111) begin
              state_q <= IDLE;
            end else begin
              state_q <= SETTLE;
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign bus.value       = value_q;
  assign bus.frame_valid = frame_valid_q;
  assign bus.seg_err     = seg_err_q;
  assign bus.anode_err   = anode_err_q;

endmodule

// File: tb/tb_ssd_scan_capture.sv
// Directed and randomized scans of the display stream, checked against a per-dwell
// reference model of digit sampling and frame assembly.
module tb_ssd_scan_capture;

  localparam int SETTLE = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;

  ssd_scan_capture_if bus ();

  ssd_scan_capture #(.SETTLE_CYCLES(SETTLE), .SEG_ACTIVE_LOW(1'b1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  logic [6:0]  font [16];
  int          n_cmp = 0, n_fail = 0;
  int          fv_cnt = 0, se_cnt = 0, ae_cnt = 0;
  bit          overlap = 1'b0;
  logic [15:0] m_value, m_stage;
  logic [3:0]  m_seen;
  int          m_fv, m_se, m_ae;
  bit          cap;

  always @(negedge clk) begin
    if (bus.frame_valid) fv_cnt++;
    if (bus.seg_err) se_cnt++;
    if (bus.anode_err) ae_cnt++;
    if (bus.frame_valid && (bus.seg_err || bus.anode_err)) overlap = 1'b1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int font_lookup(input logic [6:0] seg);
    for (int i = 0; i < 16; i++) if (font[i] == seg) return i;
    return -1;
  endfunction

  function automatic int digit_of(input logic [3:0] an);
    for (int d = 0; d < 4; d++) if ((an ^ 4'b1111) == (4'b0001 << d)) return d;
    return -1;
  endfunction

  // A dwell held long enough produces exactly one sample of that anode/segment pair.
  task automatic model_sample(input logic [3:0] an, input logic [6:0] seg);
    int d, f;
    d = digit_of(an);
    f = font_lookup(seg);
    if (d < 0) begin
      m_ae++; m_seen = 4'b0000;
    end else if (f < 0) begin
      m_se++; m_seen = 4'b0000;
    end else begin
      m_stage[d*4 +: 4] = f[3:0];
      m_seen[d] = 1'b1;
      if (m_seen == 4'b1111) begin
        m_value = m_stage; m_fv++; m_seen = 4'b0000;
      end
    end
  endtask

  task automatic dwell(input logic [3:0] an, input logic [6:0] seg, input int len);
    bus.ANODES  = an;
    bus.LED_OUT = seg;
    repeat (len) @(posedge clk);
    #1;
    if (cap && an != 4'b1111 && len >= SETTLE + 2) model_sample(an, seg);
  endtask

  task automatic scan(input logic [15:0] digits, input int len);
    logic [3:0] a;
    for (int k = 3; k >= 0; k--) begin
      a = 4'b0001 << k;
      dwell(~a, font[digits[k*4 +: 4]], len);
    end
  endtask

  task automatic settle_check(input string tag);
    dwell(4'b1111, 7'h7F, 12);
    check({tag, ".value"}, {16'h0, bus.value}, {16'h0, m_value});
    check({tag, ".frames"}, fv_cnt, m_fv);
    check({tag, ".seg_err"}, se_cnt, m_se);
    check({tag, ".anode_err"}, ae_cnt, m_ae);
  endtask

  task automatic do_reset();
    bus.ANODES = 4'b1111;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst.value", {16'h0, bus.value}, 32'h0);
    rst = 1'b1;
    m_value = 16'h0000; m_seen = 4'b0000;
  endtask

  initial begin
    logic [3:0] an, last_an, oh;
    logic [6:0] seg;
    int len;
    font = '{7'h01, 7'h4F, 7'h12, 7'h06, 7'h4C, 7'h24, 7'h20, 7'h0F,
             7'h00, 7'h04, 7'h08, 7'h60, 7'h31, 7'h42, 7'h30, 7'h38};
    m_value = 16'h0; m_stage = 16'h0; m_seen = 4'h0;
    m_fv = 0; m_se = 0; m_ae = 0; cap = 1'b1;
    bus.capture_en = 1'b1;
    bus.ANODES = 4'b1111;
    bus.LED_OUT = 7'h7F;
    repeat (3) @(posedge clk);
    #1;
    check("reset.value", {16'h0, bus.value}, 32'h0);
    check("reset.frame_valid", {31'h0, bus.frame_valid}, 32'h0);
    check("reset.seg_err", {31'h0, bus.seg_err}, 32'h0);
    check("reset.anode_err", {31'h0, bus.anode_err}, 32'h0);
    rst = 1'b1;
    settle_check("idle");

    scan(16'h1234, 20);
    settle_check("t1");

    dwell(4'b0111, font[8], 20);
    dwell(4'b1011, font[7], 20);
    dwell(4'b1101, font[6], 2);
    dwell(4'b1110, font[5], 20);
    settle_check("t2.short");
    dwell(4'b1101, font[6], 8);
    settle_check("t2.long");

    dwell(4'b0111, font[10], 20);
    dwell(4'b1011, 7'h7F, 20);
    dwell(4'b1101, font[12], 20);
    dwell(4'b1110, font[13], 20);
    settle_check("t3.blank");
    scan(16'hABCD, 20);
    settle_check("t3.abcd");

    dwell(4'b0011, font[1], 10);
    settle_check("t4.anode");
    scan(16'h000F, 20);
    settle_check("t4.000f");

    scan(16'h1234, 20);
    dwell(4'b0111, font[5], 20);
    dwell(4'b1011, font[6], 20);
    do_reset();
    settle_check("t5.reset");
    scan(16'h5678, 20);
    settle_check("t5.5678");

    bus.capture_en = 1'b0; cap = 1'b0; m_seen = 4'b0000;
    scan(16'h9999, 20);
    settle_check("t6.off");
    bus.capture_en = 1'b1; cap = 1'b1;
    dwell(4'b1111, 7'h7F, 4);
    scan(16'h9999, 20);
    settle_check("t6.on");

    for (int s = 0; s < 20; s++) begin
      last_an = 4'b1111;
      for (int k = 0; k < 6 + int'($urandom_range(0, 4)); k++) begin
        do begin
          case ($urandom_range(0, 9))
            7: an = 4'b1111;
            8, 9: an = 4'($urandom_range(0, 14));
            default: begin
              oh = 4'b0001 << $urandom_range(0, 3);
              an = ~oh;
            end
          endcase
        end while (an == last_an);
        if ($urandom_range(0, 4) != 0) seg = font[$urandom_range(0, 15)];
        else seg = 7'($urandom);
        if ($urandom_range(0, 2) == 0) len = int'($urandom_range(1, 3));
        else len = int'($urandom_range(6, 12));
        dwell(an, seg, len);
        last_an = an;
      end
      settle_check($sformatf("rand%0d", s));
    end

    check("no_overlap", {31'h0, overlap}, 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
